// File: rtl/hd_kernel_pkg.sv
// Shared types for the hd_kernel scheduler, kernel wrapper and bench.
// Optional output register stage is selected in hd_kernel_sched by HDK_OUT_REG_EN.
package hd_kernel_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned STAT_W = 16;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [OP_W-1:0] res_t;

  typedef struct packed {
    op_t a;
    op_t b;
  } op_pair_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  // Round-robin successor of idx in 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hd_rr_arb.sv
// Round-robin arbiter: first valid requester at or after ptr_i (wrapping) wins.
module hd_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               vld_o
);

  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!vld_o && req_i[ID_W'(j)]) begin
        vld_o = 1'b1;
        idx_o = ID_W'(j);
      end
    end
    if (en_i && vld_o) gnt_o = NUM_REQ'(1) << idx_o;
  end

endmodule

// File: rtl/hd_kernel_sched.sv
// Round-robin scheduler sharing one combinational hd kernel among NUM_REQ requesters.
// Define HDK_OUT_REG_EN to register the kernel result (stage S2, latency 2).
module hd_kernel_sched
  import hd_kernel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_a,
  input  logic [NUM_REQ*OP_W-1:0]  req_b,
  output op_t                      krn_a,
  output op_t                      krn_b,
  input  res_t                     krn_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output res_t                     rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [STAT_W-1:0]        stat_issued
);

  stage_e              s1_st_q, s1_st_d;
  op_pair_t            s1_op_q, s1_op_d;
  logic [ID_W-1:0]     s1_id_q, s1_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [STAT_W-1:0]   stat_q, stat_d;

  logic                s1_vld;
  logic                s1_adv;
  logic                arb_en;
  logic                arb_vld;
  logic                accept;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  op_pair_t            sel_op;

  assign s1_vld = (s1_st_q == ST_FULL);

  // Grants are suppressed while in reset so nothing is accepted that would be lost.
  assign arb_en = rst_n && (!s1_vld || s1_adv);
  assign accept = arb_en && arb_vld;

  hd_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign req_ready = arb_gnt;

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_op.a = req_a[i*OP_W +: OP_W];
        sel_op.b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    s1_st_d  = s1_st_q;
    s1_op_d  = s1_op_q;
    s1_id_d  = s1_id_q;
    rr_ptr_d = rr_ptr_q;
    stat_d   = stat_q;
    if (accept) begin
      s1_st_d  = ST_FULL;
      s1_op_d  = sel_op;
      s1_id_d  = arb_idx;
      rr_ptr_d = ID_W'(rr_next(32'(arb_idx), NUM_REQ));
      stat_d   = stat_q + STAT_W'(1);
    end else if (s1_adv) begin
      s1_st_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_st_q  <= ST_EMPTY;
      s1_op_q  <= '0;
      s1_id_q  <= '0;
      rr_ptr_q <= '0;
      stat_q   <= '0;
    end else begin
      s1_st_q  <= s1_st_d;
      s1_op_q  <= s1_op_d;
      s1_id_q  <= s1_id_d;
      rr_ptr_q <= rr_ptr_d;
      stat_q   <= stat_d;
    end
  end

  assign krn_a       = s1_op_q.a;
  assign krn_b       = s1_op_q.b;
  assign stat_issued = stat_q;

`ifdef HDK_OUT_REG_EN
  stage_e          s2_st_q, s2_st_d;
  res_t            s2_y_q, s2_y_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic            s2_vld;

  assign s2_vld = (s2_st_q == ST_FULL);
  assign s1_adv = !s2_vld || rsp_ready;

  always_comb begin
    s2_st_d = s2_st_q;
    s2_y_d  = s2_y_q;
    s2_id_d = s2_id_q;
    if (s1_vld && s1_adv) begin
      s2_st_d = ST_FULL;
      s2_y_d  = krn_y;
      s2_id_d = s1_id_q;
    end else if (rsp_ready) begin
      s2_st_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_st_q <= ST_EMPTY;
      s2_y_q  <= '0;
      s2_id_q <= '0;
    end else begin
      s2_st_q <= s2_st_d;
      s2_y_q  <= s2_y_d;
      s2_id_q <= s2_id_d;
    end
  end

  assign rsp_valid = s2_vld;
  assign rsp_data  = s2_y_q;
  assign rsp_id    = s2_id_q;
`else
  // Response is the live kernel output; S1 holds it stable under back-pressure.
  assign s1_adv    = rsp_ready;
  assign rsp_valid = s1_vld;
  assign rsp_data  = krn_y;
  assign rsp_id    = s1_id_q;
`endif

endmodule

// File: tb/tb_hd_kernel_sched.sv
// Scoreboard bench for hd_kernel_sched; kernel modelled as y = a ^ b.
// Build with +define+HDK_OUT_REG_EN to exercise the registered-output variant.
module tb_hd_kernel_sched;
  import hd_kernel_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
`ifdef HDK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_a_f;
  logic [NUM_REQ*OP_W-1:0] req_b_f;
  op_t                     krn_a, krn_b;
  res_t                    krn_y;
  logic                    rsp_valid;
  logic                    rsp_ready;
  res_t                    rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic [STAT_W-1:0]       stat_issued;

  op_t ra [NUM_REQ];
  op_t rb [NUM_REQ];
  int  rem[NUM_REQ];

  typedef struct {
    int   id;
    res_t y;
  } exp_t;

  exp_t scb[$];
  int   grant_log[$];
  int   resp_log[$];
  int   resp_cyc[$];
  int   n_chk, n_fail, cyc, acc_cnt, resp_cnt;
  logic [NUM_REQ-1:0] hs_q;

  hd_kernel_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a_f),
    .req_b       (req_b_f),
    .krn_a       (krn_a),
    .krn_b       (krn_b),
    .krn_y       (krn_y),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .stat_issued (stat_issued)
  );

  assign krn_y = krn_a ^ krn_b;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_f[i*OP_W +: OP_W] = ra[i];
      req_b_f[i*OP_W +: OP_W] = rb[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: record accepts into the scoreboard, check every response against it.
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (rst_n) begin
      chk("rdy_proto", 32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i;
          e.y  = ra[i] ^ rb[i];
          scb.push_back(e);
          grant_log.push_back(i);
          hs_q[i] = 1'b1;
          acc_cnt++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (scb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = scb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.y));
        end
        resp_log.push_back(int'(rsp_id));
        resp_cyc.push_back(cyc);
        resp_cnt++;
      end
    end
  end

  // Requester model: after a handshake, present the next operands or drop valid.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_q[i]) begin
        if (rem[i] > 0) begin
          rem[i]--;
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    hs_q = '0;
  endtask

  task automatic step();
    tick();
    @(negedge clk);
  endtask

  task automatic start_req(input int i, input int n, input logic [7:0] a, input logic [7:0] b);
    ra[i]        = a;
    rb[i]        = b;
    rem[i]       = n - 1;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((req_valid != '0 || rsp_valid) && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    resp_log.delete();
    resp_cyc.delete();
    acc_cnt  = 0;
    resp_cnt = 0;
  endtask

  initial begin
    int exp_ids[6];
    exp_ids = '{0, 1, 2, 3, 0, 1};
    n_chk = 0; n_fail = 0; cyc = 0; acc_cnt = 0; resp_cnt = 0;
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0; hs_q = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = '0; rb[i] = '0; rem[i] = 0;
    end

    // Reset values, with all requesters already waiting.
    repeat (3) @(negedge clk);
    chk("rst_krn_a", 32'(krn_a), 32'd0);
    chk("rst_krn_b", 32'(krn_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_stat", 32'(stat_issued), 32'd0);
    start_req(0, 2, 8'h11, 8'h22);
    start_req(1, 2, 8'h33, 8'h44);
    start_req(2, 1, 8'h55, 8'h66);
    start_req(3, 1, 8'h77, 8'h88);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // All four valid, rsp_ready high: rotation 0,1,2,3,0,1 at one per cycle.
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("all4_first_gnt", 32'(req_ready), 32'd1);
    wait_idle(50);
    chk("all4_nresp", 32'(resp_log.size()), 32'd6);
    if (resp_log.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("all4_id_seq", 32'(resp_log[k]), 32'(exp_ids[k]));
        chk("all4_rate", 32'(resp_cyc[k] - resp_cyc[0]), 32'(k));
      end
    end
    chk("all4_stat", 32'(stat_issued), 32'd6);

    // Single request from requester 2; latency check.
    tick();
    clear_logs();
    start_req(2, 1, 8'h35, 8'h5A);
    @(negedge clk);
    chk("single_rdy", 32'(req_ready), 32'd4);
`ifdef HDK_OUT_REG_EN
    step();
    chk("single_early", 32'(rsp_valid), 32'd0);
`endif
    step();
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data", 32'(rsp_data), 32'h6F);
    chk("single_id", 32'(rsp_id), 32'd2);
    wait_idle(20);

    // Pointer now at 3: requesters 1 and 3 -> grant 3 then 1.
    tick();
    clear_logs();
    start_req(1, 1, 8'($urandom), 8'($urandom));
    start_req(3, 1, 8'($urandom), 8'($urandom));
    wait_idle(20);
    chk("wrap_ngnt", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("wrap_gnt0", 32'(grant_log[0]), 32'd3);
      chk("wrap_gnt1", 32'(grant_log[1]), 32'd1);
    end

    // Back-pressure: fill the pipeline, stall 5 cycles, then resume at full rate.
    tick();
    clear_logs();
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) start_req(i, 3, 8'($urandom), 8'($urandom));
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      if (scb.size() > 0) begin
        chk("bp_data_hold", 32'(rsp_data), 32'(scb[0].y));
        chk("bp_id_hold", 32'(rsp_id), 32'(scb[0].id));
      end
      step();
    end
    chk("bp_accepts", 32'(acc_cnt), 32'(LAT));
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp_rate", 32'(rsp_valid), 32'd1);
      tick();
    end
    @(negedge clk);
    wait_idle(60);
    chk("bp_nacc", 32'(acc_cnt), 32'd12);
    chk("bp_nresp", 32'(resp_cnt), 32'd12);

    // Reset with S1 full discards it; first grant afterwards goes to requester 0.
    tick();
    rsp_ready = 1'b0;
    start_req(1, 1, 8'($urandom), 8'($urandom));
    step();
    step();
    start_req(0, 1, 8'($urandom), 8'($urandom));
    start_req(3, 1, 8'($urandom), 8'($urandom));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_stat", 32'(stat_issued), 32'd0);
    scb.delete();
    hs_q = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_first_gnt", 32'(req_ready), 32'd1);
    wait_idle(30);

    // Counter wrap: 65536 accepts from reset bring stat_issued back to 0.
    @(posedge clk); #1;
    rst_n = 1'b0;
    scb.delete();
    hs_q = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_req(0, 65600, 8'($urandom), 8'($urandom));
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (stat_issued != 16'hFFFF && k < 70000) begin
        step();
        k++;
      end
    end
    chk("cnt_pre_wrap", 32'(stat_issued), 32'hFFFF);
    step();
    chk("cnt_wrap", 32'(stat_issued), 32'd0);
    rem[0] = 0;
    wait_idle(20);
    chk("scb_empty", 32'(scb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
